// File: rtl/moment_bank_ram.sv
// ---------------------------------------------------------------------------
// moment_bank_ram
// Multi-channel signed moment store for the LBM lattice. NUM_CHAN independent
// RAMs share one node address space. The block provides:
//   - a hardware clear sweep, started by Reset or by clear_start,
//   - single-cycle overwrite,
//   - a two-stage read-modify-write accumulate with forwarding,
//   - registered reads with one cycle of latency and full coherence.
// Optional feature macro: MOMENT_BANK_SAT_EN
//   defined   -> an accumulate that overflows is clamped to the signed limit
//   undefined -> an accumulate that overflows wraps modulo 2^DATA_WIDTH
// ---------------------------------------------------------------------------
module moment_bank_ram #(
   parameter int DEPTH         = 16*16,
   parameter int NUM_CHAN      = 3,
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = $clog2(DEPTH),
   parameter int CHAN_WIDTH    = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     clear_start,
   output logic                     busy,
   input  logic                     wr_en,
   input  logic                     wr_mode,
   input  logic [CHAN_WIDTH-1:0]    wr_chan,
   input  logic [ADDRESS_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     rd_en,
   input  logic [CHAN_WIDTH-1:0]    rd_chan,
   input  logic [ADDRESS_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_valid,
   output logic                     overflow
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ZERO = {ADDRESS_WIDTH{1'b0}};
   localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CHAN_WIDTH-1:0]    CHAN_ZERO = {CHAN_WIDTH{1'b0}};
   localparam logic [DATA_WIDTH-1:0]    DATA_ZERO = {DATA_WIDTH{1'b0}};

   // Signed overflow of a + b = s: equal operand signs, opposite result sign.
   function automatic logic add_overflow(input logic [DATA_WIDTH-1:0] a,
                                         input logic [DATA_WIDTH-1:0] b,
                                         input logic [DATA_WIDTH-1:0] s);
      add_overflow = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) &&
                     (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
   endfunction

`ifdef MOMENT_BANK_SAT_EN
   // Signed limit reached by an overflowing add; it follows the operand sign.
   function automatic logic [DATA_WIDTH-1:0] sat_limit(input logic negative);
      if (negative) begin
         sat_limit = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         sat_limit = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   endfunction
`endif

   // A channel select is usable only if it names an existing channel.
   function automatic logic chan_in_range(input logic [CHAN_WIDTH-1:0] c);
      chan_in_range = (int'(c) < NUM_CHAN);
   endfunction

   // Storage
   logic [DATA_WIDTH-1:0] mem_q [0:NUM_CHAN-1][0:DEPTH-1];

   // FSM state and clear-sweep counter
   state_t                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
   logic                     busy_q, busy_d;

   // Accumulate stage-2 register (old value captured at stage 1)
   logic                     acc_valid_q, acc_valid_d;
   logic [CHAN_WIDTH-1:0]    acc_chan_q, acc_chan_d;
   logic [ADDRESS_WIDTH-1:0] acc_addr_q, acc_addr_d;
   logic [DATA_WIDTH-1:0]    acc_old_q, acc_old_d;
   logic [DATA_WIDTH-1:0]    acc_opnd_q, acc_opnd_d;

   // Read port and sticky flag
   logic                     rd_valid_q, rd_valid_d;
   logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
   logic                     overflow_q, overflow_d;

   // Combinational helpers
   logic                     cmd_ok_s;
   logic                     clr_we_s;
   logic                     clear_go_s;
   logic                     wr_chan_ok_s;
   logic                     rd_chan_ok_s;
   logic                     ow_we_s;
   logic                     acc_issue_s;
   logic                     rd_issue_s;
   logic                     acc_hit_wr_s;
   logic                     acc_hit_rd_s;
   logic                     commit_s;
   logic                     acc_ovf_s;
   logic [CHAN_WIDTH-1:0]    wr_idx_s;
   logic [CHAN_WIDTH-1:0]    rd_idx_s;
   logic [DATA_WIDTH-1:0]    acc_raw_s;
   logic [DATA_WIDTH-1:0]    acc_sum_s;
   logic [DATA_WIDTH-1:0]    wr_cur_s;
   logic [DATA_WIDTH-1:0]    rd_cur_s;

   // FSM state register: Reset restarts the clear sweep from address 0.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= ST_CLEAR;
         cnt_q   <= ADDR_ZERO;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   // FSM next state: sweep one address per cycle, leave after the last one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_CLEAR: begin
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_IDLE;
               cnt_d   = ADDR_ZERO;
            end else begin
               state_d = ST_CLEAR;
               cnt_d   = cnt_q + ADDR_ONE;
            end
         end
         ST_IDLE: begin
            if (clear_start) begin
               state_d = ST_CLEAR;
               cnt_d   = ADDR_ZERO;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = cnt_q;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            cnt_d   = ADDR_ZERO;
         end
      endcase
   end

   // FSM outputs: busy tracks the next state so the flop matches the sweep;
   // commands are accepted only in IDLE and a same-cycle clear drops them.
   always_comb begin
      busy_d     = (state_d == ST_CLEAR);
      clr_we_s   = (state_q == ST_CLEAR) && !Reset;
      clear_go_s = (state_q == ST_IDLE) && clear_start && !Reset;
      cmd_ok_s   = (state_q == ST_IDLE) && !clear_start && !Reset;
   end

   // Stage-2 sum, shared by the memory commit and every forwarding path.
   always_comb begin
      acc_raw_s = acc_old_q + acc_opnd_q;
      acc_ovf_s = add_overflow(acc_old_q, acc_opnd_q, acc_raw_s);
`ifdef MOMENT_BANK_SAT_EN
      if (acc_ovf_s) begin
         acc_sum_s = sat_limit(acc_opnd_q[DATA_WIDTH-1]);
      end else begin
         acc_sum_s = acc_raw_s;
      end
`else
      acc_sum_s = acc_raw_s;
`endif
   end

   // Command decode and coherent current-value lookup for both ports.
   always_comb begin
      wr_chan_ok_s = chan_in_range(wr_chan);
      rd_chan_ok_s = chan_in_range(rd_chan);
      ow_we_s      = cmd_ok_s && wr_en && !wr_mode && wr_chan_ok_s;
      acc_issue_s  = cmd_ok_s && wr_en && wr_mode && wr_chan_ok_s;
      rd_issue_s   = cmd_ok_s && rd_en;

      if (wr_chan_ok_s) begin
         wr_idx_s = wr_chan;
      end else begin
         wr_idx_s = CHAN_ZERO;
      end
      if (rd_chan_ok_s) begin
         rd_idx_s = rd_chan;
      end else begin
         rd_idx_s = CHAN_ZERO;
      end

      acc_hit_wr_s = acc_valid_q && (acc_chan_q == wr_chan) && (acc_addr_q == wr_addr);
      acc_hit_rd_s = acc_valid_q && (acc_chan_q == rd_chan) && (acc_addr_q == rd_addr);

      // The in-flight sum is the newest value of its location.
      if (acc_hit_wr_s) begin
         wr_cur_s = acc_sum_s;
      end else begin
         wr_cur_s = mem_q[wr_idx_s][wr_addr];
      end
      if (acc_hit_rd_s) begin
         rd_cur_s = acc_sum_s;
      end else begin
         rd_cur_s = mem_q[rd_idx_s][rd_addr];
      end

      // An overwrite landing on the in-flight location supersedes the sum.
      commit_s = acc_valid_q && !Reset && !(ow_we_s && acc_hit_wr_s);
   end

   // Memory write ports: clear sweep, stage-2 commit, overwrite.
   always_ff @(posedge Clk) begin
      if (clr_we_s) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            mem_q[c][cnt_q] <= DATA_ZERO;
         end
      end else begin
         if (commit_s) begin
            mem_q[acc_chan_q][acc_addr_q] <= acc_sum_s;
         end
         if (ow_we_s) begin
            mem_q[wr_idx_s][wr_addr] <= wr_data;
         end
      end
   end

   // Next values for the accumulate pipeline, read port and overflow flag.
   always_comb begin
      if (acc_issue_s) begin
         acc_valid_d = 1'b1;
         acc_chan_d  = wr_chan;
         acc_addr_d  = wr_addr;
         acc_old_d   = wr_cur_s;
         acc_opnd_d  = wr_data;
      end else begin
         acc_valid_d = 1'b0;
         acc_chan_d  = acc_chan_q;
         acc_addr_d  = acc_addr_q;
         acc_old_d   = acc_old_q;
         acc_opnd_d  = acc_opnd_q;
      end

      if (rd_issue_s) begin
         rd_valid_d = 1'b1;
         if (rd_chan_ok_s) begin
            rd_data_d = rd_cur_s;
         end else begin
            rd_data_d = DATA_ZERO;
         end
      end else begin
         rd_valid_d = 1'b0;
         rd_data_d  = rd_data_q;
      end

      // A clear wins over an overflow from the commit in the same cycle.
      if (clear_go_s) begin
         overflow_d = 1'b0;
      end else if (acc_valid_q && acc_ovf_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Datapath registers; Reset discards any pending accumulate.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         acc_valid_q <= 1'b0;
         acc_chan_q  <= CHAN_ZERO;
         acc_addr_q  <= ADDR_ZERO;
         acc_old_q   <= DATA_ZERO;
         acc_opnd_q  <= DATA_ZERO;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= DATA_ZERO;
         overflow_q  <= 1'b0;
      end else begin
         acc_valid_q <= acc_valid_d;
         acc_chan_q  <= acc_chan_d;
         acc_addr_q  <= acc_addr_d;
         acc_old_q   <= acc_old_d;
         acc_opnd_q  <= acc_opnd_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
         overflow_q  <= overflow_d;
      end
   end

   assign busy     = busy_q;
   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_moment_bank_ram.sv
// ---------------------------------------------------------------------------
// tb_moment_bank_ram
// Randomised and directed stimulus against a plain array model of the moment
// bank. Each read pushes its expected word and due cycle into a scoreboard;
// an independent monitor checks rd_valid every cycle and pops on a match.
// ---------------------------------------------------------------------------
module tb_moment_bank_ram;

   localparam int DEPTH = 256;
   localparam int NCH   = 3;

   logic        Clk;
   logic        Reset;
   logic        clear_start;
   logic        busy;
   logic        wr_en;
   logic        wr_mode;
   logic [1:0]  wr_chan;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [1:0]  rd_chan;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        overflow;

   moment_bank_ram dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .clear_start (clear_start),
      .busy        (busy),
      .wr_en       (wr_en),
      .wr_mode     (wr_mode),
      .wr_chan     (wr_chan),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_en       (rd_en),
      .rd_chan     (rd_chan),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .overflow    (overflow)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   exp_t        sb_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;

   // Reference model: plain arrays, commands applied in issue order.
   logic [31:0] model [0:NCH-1][0:DEPTH-1];
   int          busy_cnt = 0;
   bit          ovf_flag = 1'b0;
   bit          ovf_pend = 1'b0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic model_zero();
      for (int c = 0; c < NCH; c++)
         for (int a = 0; a < DEPTH; a++)
            model[c][a] = 32'h0;
   endtask

   // Signed add of the specification with either wrap or clamp.
   task automatic model_acc(input logic [31:0] old, input logic [31:0] d,
                            output logic [31:0] res, output bit ovf);
      longint s;
      s   = longint'($signed(old)) + longint'($signed(d));
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`ifdef MOMENT_BANK_SAT_EN
      if (s > 64'sd2147483647)       res = 32'h7FFF_FFFF;
      else if (s < -64'sd2147483648) res = 32'h8000_0000;
      else                           res = s[31:0];
`else
      res = s[31:0];
`endif
   endtask

   // One command cycle: drive inputs, update the model, clock, check flags.
   task automatic issue(input bit we, input bit mode, input int wc, input int wa,
                        input logic [31:0] wd, input bit re, input int rc,
                        input int ra, input bit clr);
      logic [31:0] res;
      bit          ovf;
      wr_en = we; wr_mode = mode; wr_chan = wc[1:0]; wr_addr = wa[7:0]; wr_data = wd;
      rd_en = re; rd_chan = rc[1:0]; rd_addr = ra[7:0]; clear_start = clr;
      if (busy_cnt > 0) begin
         busy_cnt--;
      end else if (clr) begin
         model_zero();
         ovf_flag = 1'b0;
         ovf_pend = 1'b0;
         busy_cnt = DEPTH;
      end else begin
         ovf_flag = ovf_flag | ovf_pend;
         ovf_pend = 1'b0;
         if (re) begin
            exp_t e;
            e.due  = cyc + 1;
            e.data = (rc < NCH) ? model[rc][ra] : 32'h0;
            sb_q.push_back(e);
         end
         if (we && wc < NCH) begin
            if (mode) begin
               model_acc(model[wc][wa], wd, res, ovf);
               model[wc][wa] = res;
               ovf_pend = ovf;
            end else begin
               model[wc][wa] = wd;
            end
         end
      end
      step();
      check("busy", {31'b0, busy}, {31'b0, (busy_cnt > 0)});
      check("overflow", {31'b0, overflow}, {31'b0, ovf_flag});
   endtask

   task automatic idle();
      issue(1'b0, 1'b0, 0, 0, 32'h0, 1'b0, 0, 0, 1'b0);
   endtask

   task automatic rd(input int c, input int a);
      issue(1'b0, 1'b0, 0, 0, 32'h0, 1'b1, c, a, 1'b0);
   endtask

   // Reset with random command strobes, which must be ignored.
   task automatic do_reset();
      Reset = 1'b1;
      wr_en = 1'($urandom); wr_mode = 1'($urandom); wr_chan = 2'($urandom);
      wr_addr = 8'($urandom); wr_data = $urandom; rd_en = 1'($urandom);
      rd_chan = 2'($urandom); rd_addr = 8'($urandom); clear_start = 1'($urandom);
      model_zero();
      busy_cnt = DEPTH;
      ovf_flag = 1'b0;
      ovf_pend = 1'b0;
      step();
      Reset = 1'b0;
      check("reset_busy", {31'b0, busy}, 32'h1);
      check("reset_rd_valid", {31'b0, rd_valid}, 32'h0);
      check("reset_rd_data", rd_data, 32'h0);
      check("reset_overflow", {31'b0, overflow}, 32'h0);
   endtask

   // Ride out a sweep with random strobes; returns the observed busy length.
   task automatic sweep(output int n);
      n = 1;
      for (int k = 0; k < 300; k++) begin
         issue(1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 255),
               $urandom, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 255), 1'b0);
         if (busy === 1'b1) n++;
         else break;
      end
   endtask

   task automatic read_all();
      for (int c = 0; c < 4; c++)
         for (int a = 0; a < DEPTH; a++)
            rd(c, a);
   endtask

   function automatic logic [31:0] rand_data();
      case ($urandom_range(0, 3))
         0:       rand_data = 32'h7FFF_FFF0 + 32'($urandom_range(0, 15));
         1:       rand_data = 32'h8000_0000 + 32'($urandom_range(0, 15));
         default: rand_data = $urandom;
      endcase
   endfunction

   // Monitor: rd_valid must be high exactly on the due cycle of the oldest read.
   initial begin
      forever begin
         @(posedge Clk);
         cyc = cyc + 1;
         #2;
         if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            check("rd_valid", {31'b0, rd_valid}, 32'h1);
            check("rd_data", rd_data, e.data);
         end else begin
            check("rd_valid_idle", {31'b0, rd_valid}, 32'h0);
         end
      end
   end

   initial begin
      int n;
      Reset = 1'b0; clear_start = 1'b0; wr_en = 1'b0; wr_mode = 1'b0;
      wr_chan = 2'd0; wr_addr = 8'd0; wr_data = 32'h0;
      rd_en = 1'b0; rd_chan = 2'd0; rd_addr = 8'd0;

      // Reset sweep lasts exactly DEPTH cycles, then everything reads 0.
      do_reset();
      sweep(n);
      check("busy_len_reset", n, DEPTH);
      read_all();

      // Overwrite ch1/5 then read it and its neighbours in other channels.
      issue(1'b1, 1'b0, 1, 5, 32'd100, 1'b0, 0, 0, 1'b0);
      rd(1, 5);
      rd(0, 5);
      rd(2, 5);

      // Back-to-back accumulates with a same-cycle read of the pre-write value.
      issue(1'b1, 1'b1, 0, 7, 32'd3, 1'b0, 0, 0, 1'b0);
      issue(1'b1, 1'b1, 0, 7, 32'd4, 1'b1, 0, 7, 1'b0);
      issue(1'b1, 1'b1, 0, 7, -32'sd2, 1'b0, 0, 0, 1'b0);
      rd(0, 7);

      // Overflow on ch2/9.
      issue(1'b1, 1'b0, 2, 9, 32'h7FFF_FFFF, 1'b0, 0, 0, 1'b0);
      issue(1'b1, 1'b1, 2, 9, 32'h1, 1'b0, 0, 0, 1'b0);
      idle();
      check("overflow_set", {31'b0, overflow}, 32'h1);
      rd(2, 9);

      // Overwrite landing on an in-flight accumulate supersedes the sum.
      issue(1'b1, 1'b1, 1, 20, 32'd50, 1'b0, 0, 0, 1'b0);
      issue(1'b1, 1'b0, 1, 20, 32'd9, 1'b1, 1, 20, 1'b0);
      rd(1, 20);
      issue(1'b1, 1'b0, 3, 1, 32'd77, 1'b1, 3, 1, 1'b0);

      // clear_start with same-cycle commands, then strobes during the sweep.
      issue(1'b1, 1'b0, 0, 3, 32'd55, 1'b1, 1, 5, 1'b1);
      sweep(n);
      check("busy_len_clear", n, DEPTH);
      check("overflow_cleared", {31'b0, overflow}, 32'h0);
      read_all();

      // Reset in the middle of an accumulate stream.
      issue(1'b1, 1'b1, 0, 7, 32'd10, 1'b0, 0, 0, 1'b0);
      issue(1'b1, 1'b1, 0, 7, 32'd11, 1'b0, 0, 0, 1'b0);
      do_reset();
      sweep(n);
      rd(0, 7);

      // Randomised traffic over a small address window to provoke hazards.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 699) == 0) begin
            do_reset();
         end else begin
            issue(1'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  rand_data(), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 399) == 0));
         end
      end
      for (int k = 0; k < 300 && busy_cnt > 0; k++) idle();
      for (int c = 0; c < 4; c++)
         for (int a = 0; a < 4; a++)
            rd(c, a);

      // Drain the scoreboard.
      for (int k = 0; k < 4; k++) idle();
      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain got=%0d exp=0 pending reads", sb_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
